// File: rtl/neuro_pkg.sv
// Shared types and constants for the leaky integrate-and-fire scheduler.
// Holds the scheduler state encoding, neuron geometry and weight-lane extraction.
package neuro_pkg;

  localparam int NUM_NEURONS    = 4;
  localparam int WEIGHT_W       = 8;
  localparam int VMEM_W_DEFAULT = 16;
  localparam int SPIKE_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_LEAK,
    ST_FIRE,
    ST_DONE
  } state_e;

  // Byte lane idx of a WVR word is the signed weight for neuron idx.
  function automatic logic signed [WEIGHT_W-1:0] weight_of(input logic [SPIKE_W-1:0] word,
                                                           input int idx);
    return word[WEIGHT_W*idx +: WEIGHT_W];
  endfunction

endpackage

// File: rtl/prio_enc32.sv
// 32-bit lowest-set-bit priority encoder.
// Returns the index of the least significant set bit and a valid flag.
module prio_enc32 (
  input  logic [31:0] req,
  output logic [4:0]  idx,
  output logic        valid
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
    valid = |req;
  end

endmodule

// File: rtl/lif_scheduler.sv
// Timestep scheduler for four leaky integrate-and-fire neurons.
// Walks the set bits of an SVR spike word, accumulates WVR weights, leaks, then fires.
module lif_scheduler
  import neuro_pkg::*;
#(
  parameter logic [4:0] SPIKE_ADDR = 5'd0,
  parameter int         VMEM_W     = VMEM_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            clear,
  input  logic signed [VMEM_W-1:0]        threshold,
  input  logic [3:0]                      leak_shift,
  output logic [4:0]                      svr_readaddr,
  input  logic [SPIKE_W-1:0]              svr_readdata,
  output logic [4:0]                      wvr_readaddr,
  input  logic [SPIKE_W-1:0]              wvr_readdata,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_NEURONS-1:0]          spike_out,
  output logic [NUM_NEURONS*VMEM_W-1:0]   vmem_flat
);

  localparam logic signed [VMEM_W-1:0] VMEM_MAX = {1'b0, {(VMEM_W-1){1'b1}}};
  localparam logic signed [VMEM_W-1:0] VMEM_MIN = {1'b1, {(VMEM_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [SPIKE_W-1:0]        pending_q, pending_d;
  logic signed [VMEM_W-1:0]  vmem_q [NUM_NEURONS];
  logic signed [VMEM_W-1:0]  vmem_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]    spike_q, spike_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [4:0]                k;
  logic                      k_valid;

  prio_enc32 u_prio_enc (
    .req   (pending_q),
    .idx   (k),
    .valid (k_valid)
  );

  // One extra bit catches overflow; the top two bits disagree exactly when the sum left range.
  function automatic logic signed [VMEM_W-1:0] sat_add(input logic signed [VMEM_W-1:0]   v,
                                                       input logic signed [WEIGHT_W-1:0] w);
    logic signed [VMEM_W:0] sum;
    sum = {v[VMEM_W-1], v} + {{(VMEM_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
    if (sum[VMEM_W] != sum[VMEM_W-1]) begin
      return sum[VMEM_W] ? VMEM_MIN : VMEM_MAX;
    end
    return sum[VMEM_W-1:0];
  endfunction

  // Subtracting a right-shifted copy can only shrink |v|, so no saturation is needed here.
  function automatic logic signed [VMEM_W-1:0] leak(input logic signed [VMEM_W-1:0] v,
                                                    input logic [3:0]               sh);
    if (sh == 4'd0) return v;
    return v - (v >>> sh);
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    vmem_d    = vmem_q;
    spike_d   = spike_q;

    unique case (state_q)
      ST_IDLE: begin
        // Clear and start may coincide: the zeroing lands before the run reads vmem.
        if (clear) begin
          for (int i = 0; i < NUM_NEURONS; i++) vmem_d[i] = '0;
        end
        if (start) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        pending_d = svr_readdata;
        state_d   = (svr_readdata != '0) ? ST_ACCUM : ST_LEAK;
      end

      ST_ACCUM: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          vmem_d[i] = sat_add(vmem_q[i], weight_of(wvr_readdata, i));
        end
        pending_d = pending_q & ~(SPIKE_W'(1) << k);
        if (!k_valid || pending_d == '0) state_d = ST_LEAK;
      end

      ST_LEAK: begin
        for (int i = 0; i < NUM_NEURONS; i++) vmem_d[i] = leak(vmem_q[i], leak_shift);
        state_d = ST_FIRE;
      end

      ST_FIRE: begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          if (vmem_q[i] >= threshold) begin
            spike_d[i] = 1'b1;
            vmem_d[i]  = '0;
          end else begin
            spike_d[i] = 1'b0;
          end
        end
        state_d = ST_DONE;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      // NOTE: the membrane file is only four registers and must read zero straight out of reset, so it is reset like any other flop.
      for (int i = 0; i < NUM_NEURONS; i++) vmem_q[i] <= '0;
      spike_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value, independent of statement order.
      state_q   <= state_d;
      pending_q <= pending_d;
      vmem_q    <= vmem_d;
      spike_q   <= spike_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign svr_readaddr = (state_q == ST_LOAD)  ? SPIKE_ADDR : 5'd0;
  assign wvr_readaddr = (state_q == ST_ACCUM) ? k          : 5'd0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign spike_out    = spike_q;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_flat
    assign vmem_flat[VMEM_W*g +: VMEM_W] = vmem_q[g];
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: chained timestep table plus hand-written
// sequences for saturation, start during a run and reset mid-accumulation.
module tb_lif_scheduler;

  localparam logic [4:0] SPIKE_ADDR = 5'd7;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               clear;
  logic signed [15:0] threshold;
  logic [3:0]         leak_shift;
  logic [4:0]         svr_readaddr;
  logic [31:0]        svr_readdata;
  logic [4:0]         wvr_readaddr;
  logic [31:0]        wvr_readdata;
  logic               busy;
  logic               done;
  logic [3:0]         spike_out;
  logic [63:0]        vmem_flat;

  logic [31:0]        spike_word;
  logic [31:0]        wvr_mem [32];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // SVR returns a poison pattern for any address but the spike register.
  assign svr_readdata = (svr_readaddr == SPIKE_ADDR) ? spike_word : 32'hA5A5_A5A5;
  assign wvr_readdata = wvr_mem[wvr_readaddr];

  lif_scheduler #(.SPIKE_ADDR(SPIKE_ADDR), .VMEM_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .clear        (clear),
    .threshold    (threshold),
    .leak_shift   (leak_shift),
    .svr_readaddr (svr_readaddr),
    .svr_readdata (svr_readdata),
    .wvr_readaddr (wvr_readaddr),
    .wvr_readdata (wvr_readdata),
    .busy         (busy),
    .done         (done),
    .spike_out    (spike_out),
    .vmem_flat    (vmem_flat)
  );

  typedef struct {
    logic [31:0]       spike;
    logic [3:0]        leak;
    int                thr;
    logic              clr;
    int                exp_done;
    logic [3:0]        exp_spike;
    logic [3:0][15:0]  exp_v;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] sp, input logic [3:0] lk, input int thr,
                              input logic clr, input int dc, input logic [3:0] so,
                              input int v0, input int v1, input int v2, input int v3);
    vec_t r;
    r.spike = sp; r.leak = lk; r.thr = thr; r.clr = clr;
    r.exp_done = dc; r.exp_spike = so;
    r.exp_v[0] = 16'(v0); r.exp_v[1] = 16'(v1); r.exp_v[2] = 16'(v2); r.exp_v[3] = 16'(v3);
    return r;
  endfunction

  function automatic int vm(input int i);
    logic signed [15:0] t;
    t = vmem_flat[16*i +: 16];
    return int'(t);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One timestep: returns the cycle done rose (-1 on timeout), whether the
  // SVR/WVR address trace matched the set bits of the spike word, and whether
  // done dropped again the following cycle.
  task automatic run_ts(input logic [31:0] sp, input logic [3:0] lk, input int thr,
                        input logic clr, output int done_cyc, output bit addr_ok,
                        output bit pulse_ok);
    int bits[$];
    int exp_w;
    int exp_s;
    for (int b = 0; b < 32; b++) if (sp[b]) bits.push_back(b);
    done_cyc = -1;
    addr_ok  = 1'b1;
    @(posedge clk); #1;
    spike_word = sp; leak_shift = lk; threshold = 16'(thr); clear = clr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      exp_s = (c == 1) ? int'(SPIKE_ADDR) : 0;
      exp_w = (c >= 2 && c <= bits.size() + 1) ? bits[c-2] : 0;
      if (int'(svr_readaddr) != exp_s || int'(wvr_readaddr) != exp_w) begin
        if (addr_ok) $display("FAIL addr_trace cycle %0d: got svr=%0d wvr=%0d expected svr=%0d wvr=%0d",
                              c, svr_readaddr, wvr_readaddr, exp_s, exp_w);
        addr_ok = 1'b0;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    @(negedge clk);
    pulse_ok = !done && !busy;
  endtask

  vec_t vecs [7];
  int   dc;
  bit   aok, pok;
  int   n_done;

  initial begin
    reset = 1'b0; start = 1'b0; clear = 1'b0;
    threshold = '0; leak_shift = '0; spike_word = '0;
    for (int a = 0; a < 32; a++) wvr_mem[a] = 32'h0;
    wvr_mem[0] = 32'h0102_0304;
    wvr_mem[2] = 32'h0101_0101;
    wvr_mem[3] = 32'hFF80_FE00;
    wvr_mem[4] = 32'h0000_0040;

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_spike", spike_out, 0);
    check("reset_vmem_zero", (vmem_flat == 64'h0), 1);
    @(posedge clk); #1 reset = 1'b1;

    // Chained timesteps: membrane state carries from one row to the next.
    vecs[0] = mk(32'h0000_0000, 4'd0,   4, 1'b1, 4, 4'b0000,  0,  0,   0, 0);
    vecs[1] = mk(32'h0000_0005, 4'd0,   4, 1'b0, 6, 4'b0011,  0,  0,   3, 2);
    vecs[2] = mk(32'h0000_0010, 4'd0, 100, 1'b0, 5, 4'b0000, 64,  0,   3, 2);
    vecs[3] = mk(32'h0000_0000, 4'd2, 100, 1'b0, 4, 4'b0000, 48,  0,   3, 2);
    vecs[4] = mk(32'h0000_0000, 4'd0, 100, 1'b0, 4, 4'b0000, 48,  0,   3, 2);
    vecs[5] = mk(32'h0000_0008, 4'd1,  -1, 1'b0, 5, 4'b1011,  0,  0, -62, 0);
    vecs[6] = mk(32'h0000_0005, 4'd0,   4, 1'b1, 6, 4'b0011,  0,  0,   3, 2);

    for (int v = 0; v < 7; v++) begin
      run_ts(vecs[v].spike, vecs[v].leak, vecs[v].thr, vecs[v].clr, dc, aok, pok);
      check($sformatf("vec%0d_done_cycle", v), dc, vecs[v].exp_done);
      check($sformatf("vec%0d_addr_trace", v), aok, 1);
      check($sformatf("vec%0d_done_pulse", v), pok, 1);
      check($sformatf("vec%0d_spike_out", v), spike_out, vecs[v].exp_spike);
      for (int i = 0; i < 4; i++)
        check($sformatf("vec%0d_vmem%0d", v, i), vm(i), int'($signed(vecs[v].exp_v[i])));
    end

    // Clear alone in IDLE, then nine saturating timesteps.
    for (int a = 0; a < 32; a++) wvr_mem[a] = 32'h7F7F_7F7F;
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check("clear_only_vmem2", vm(2), 0);
    check("clear_only_busy", busy, 0);
    for (int s = 1; s <= 9; s++) begin
      run_ts(32'hFFFF_FFFF, 4'd0, 32'h7FFF, 1'b0, dc, aok, pok);
      check($sformatf("sat%0d_done_cycle", s), dc, 36);
      if (s == 1) check("sat1_addr_trace", aok, 1);
      if (s <= 8) begin
        check($sformatf("sat%0d_spike_out", s), spike_out, 0);
        for (int i = 0; i < 4; i++) check($sformatf("sat%0d_vmem%0d", s, i), vm(i), 4064 * s);
      end else begin
        check("sat9_spike_out", spike_out, 4'b1111);
        for (int i = 0; i < 4; i++) check($sformatf("sat9_vmem%0d", i), vm(i), 0);
      end
    end

    // Start pulsed while accumulating must not launch a second run.
    @(posedge clk); #1;
    spike_word = 32'h0000_00F0; threshold = 16'sd100; leak_shift = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (c == 2) start = 1'b1;
      if (c == 3) start = 1'b0;
    end
    check("start_in_accum_done_count", n_done, 1);
    check("start_in_accum_spike_out", spike_out, 4'b1111);
    check("start_in_accum_idle", busy, 0);

    // Reset in the middle of accumulation.
    @(posedge clk); #1;
    spike_word = 32'h0000_00FF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_vmem_nonzero", (vmem_flat != 64'h0), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_spike", spike_out, 0);
    check("mid_reset_vmem_zero", (vmem_flat == 64'h0), 1);
    @(posedge clk); #1 reset = 1'b1;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("post_reset_no_resume", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 SHALL have parameter SPIKE_ADDR, default 5'd0: the SVR address holding the 32-bit input spike word.
REQ-002 SHALL have parameter VMEM_W, default 16: the signed membrane-potential width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin one timestep; sampled only in IDLE.
REQ-006 SHALL have port clear, input, 1 bit: zero all membrane potentials; honoured only in IDLE.
REQ-007 SHALL have port threshold, input, VMEM_W bits: signed firing threshold.
REQ-008 SHALL have port leak_shift, input, 4 bits: leak is v >>> leak_shift; 0 means no leak.
REQ-009 SHALL have port svr_readaddr, output, 5 bits: SVR read address.
REQ-010 SHALL have port svr_readdata, input, 32 bits: SVR combinational read data.
REQ-011 SHALL have port wvr_readaddr, output, 5 bits: WVR read address (input index k).
REQ-012 SHALL have port wvr_readdata, input, 32 bits: four signed 8-bit weights; byte i [8i+7:8i] feeds neuron i.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE; drives pipeline stall.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at timestep completion.
REQ-015 SHALL have port spike_out, output, 4 bits: registered fire vector, held until the next FIRE.
REQ-016 SHALL have port vmem_flat, output, 4*VMEM_W bits: membrane potentials; neuron i at [VMEM_W*i +: VMEM_W].

Function
REQ-017 SHALL implement states IDLE, LOAD, ACCUM, LEAK, FIRE, DONE.
REQ-018 IDLE: start=1 SHALL transition to LOAD; clear=1 SHALL zero all vmem; when both are high, clear applies first, then the run proceeds.
REQ-019 LOAD: SHALL drive svr_readaddr=SPIKE_ADDR and capture svr_readdata into a 32-bit pending mask; nonzero mask -> ACCUM, zero mask -> LEAK.
REQ-020 ACCUM: each cycle SHALL select k = lowest set bit of pending, drive wvr_readaddr=k, add sign-extended byte i of wvr_readdata to vmem[i] for all four neurons, and clear bit k; go to LEAK once pending becomes zero.
REQ-021 Additions SHALL saturate to [-2^(VMEM_W-1), 2^(VMEM_W-1)-1].
REQ-022 LEAK: SHALL set vmem[i] = vmem[i] - (vmem[i] >>> leak_shift) (arithmetic shift) when leak_shift != 0, and leave vmem unchanged when leak_shift = 0.
REQ-023 FIRE: for each i, vmem[i] >= threshold (signed compare) SHALL set spike_out[i]=1 and vmem[i]=0; otherwise spike_out[i]=0 and vmem[i] is held.
REQ-024 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 Latency: with start sampled in cycle 0 and P = popcount(spike word), done SHALL be high in cycle P+4; 4 cycles minimum, 36 maximum.
REQ-026 start and clear SHALL be ignored while busy=1.
REQ-027 wvr_readaddr and svr_readaddr SHALL be 0 outside ACCUM and LOAD respectively.
REQ-028 vmem SHALL persist across timesteps.

Reset
REQ-029 reset low SHALL immediately force IDLE, vmem=0, spike_out=0, pending=0, done=0, busy=0, including mid-operation; no partial run resumes.

Structure
REQ-030 Package neuro_pkg SHALL hold the state enum, NUM_NEURONS=4, WEIGHT_W=8 and VMEM_W default.
REQ-031 Sub-module prio_enc32 (32-bit lowest-set-bit encoder: 5-bit index plus valid) SHALL be the only child.

Verification
REQ-032 Reset -> busy=0, done=0, spike_out=0, vmem_flat=0.
REQ-033 Spike word 0, start -> no WVR reads, done in cycle 4, spike_out=0000.
REQ-034 Spike word 0x00000005, WVR[0]=0x01020304, WVR[2]=0x01010101, leak_shift=0, threshold=4 -> wvr_readaddr 0 then 2, done in cycle 6, spike_out=0011, vmem={3:2, 2:3, 1:0, 0:0}.
REQ-035 Spike word 0xFFFFFFFF, all WVR=0x7F7F7F7F, threshold=0x7FFF, leak_shift=0, 9 timesteps -> spike_out=0000 for timesteps 1-8 (vmem=32512 after 8), 9th saturates to 32767 and fires 1111, vmem -> 0.
REQ-036 vmem0=64, leak_shift=2, spike word 0, threshold=100 -> vmem0=48 and no fire; leak_shift=0 -> vmem0 unchanged.
REQ-037 start pulsed during ACCUM is ignored (one done only); reset low mid-ACCUM -> next cycle busy=0, vmem=0, no done.
